// File: rtl/light_driver.sv
// light_driver: traffic-light lamp driver. Runs a lamp test after reset, inserts
// an all-off gap between light codes, dims each colour lamp with a fixed PWM
// duty and sequences the walk lamp (steady, then flashing) from an external
// blink timebase.
module light_driver #(
  parameter int C_DUTY_RED    = 255,
  parameter int C_DUTY_GREEN  = 255,
  parameter int C_DUTY_YELLOW = 255,
  parameter int C_TEST        = 4,
  parameter int C_BLANK       = 1000,
  parameter int C_WALK_STEADY = 50
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       blink,
  input  logic [1:0] inLight,
  output logic       outRed,
  output logic       outYellow,
  output logic       outGreen,
  output logic       outWalk,
  output logic       outDontWalk,
  output logic       outChange
);

  typedef enum logic [1:0] {S_TEST, S_RUN, S_BLANK} state_t;

  localparam logic [7:0]  DUTY_R      = 8'(C_DUTY_RED);
  localparam logic [7:0]  DUTY_G      = 8'(C_DUTY_GREEN);
  localparam logic [7:0]  DUTY_Y      = 8'(C_DUTY_YELLOW);
  localparam logic [7:0]  TEST_LAST   = 8'(C_TEST - 1);
  localparam logic [15:0] BLANK_LAST  = 16'(C_BLANK - 1);
  localparam logic [7:0]  WALK_STEADY = 8'(C_WALK_STEADY);

  // Light codes
  localparam logic [1:0] CODE_RED    = 2'b00;
  localparam logic [1:0] CODE_GREEN  = 2'b01;
  localparam logic [1:0] CODE_YELLOW = 2'b10;
  localparam logic [1:0] CODE_WALK   = 2'b11;

  state_t      state_q, state_d;
  logic        blink_s1_q, blink_s1_d;
  logic        blink_s2_q, blink_s2_d;
  logic        blink_s3_q, blink_s3_d;
  logic [1:0]  code_q, code_d;        // registered inLight
  logic [1:0]  active_q, active_d;    // code currently being displayed
  logic [7:0]  pwm_q, pwm_d;
  logic [7:0]  test_q, test_d;
  logic [15:0] blank_q, blank_d;
  logic [7:0]  walk_cnt_q, walk_cnt_d;
  logic        flash_q, flash_d;
  logic        out_red_q, out_red_d;
  logic        out_yellow_q, out_yellow_d;
  logic        out_green_q, out_green_d;
  logic        out_walk_q, out_walk_d;
  logic        out_dwalk_q, out_dwalk_d;
  logic        out_change_q, out_change_d;

  logic        blink_evt;
  logic        en_red, en_green, en_yellow;

  assign blink_evt = blink_s2_q & ~blink_s3_q;
  assign en_red    = pwm_q < DUTY_R;
  assign en_green  = pwm_q < DUTY_G;
  assign en_yellow = pwm_q < DUTY_Y;

  // Next-state: synchronizer, PWM counter, FSM with blanking and walk sequencer
  always_comb begin
    blink_s1_d   = blink;
    blink_s2_d   = blink_s1_q;
    blink_s3_d   = blink_s2_q;
    code_d       = inLight;
    pwm_d        = pwm_q + 8'd1;
    state_d      = state_q;
    active_d     = active_q;
    test_d       = test_q;
    blank_d      = blank_q;
    walk_cnt_d   = walk_cnt_q;
    flash_d      = flash_q;
    out_change_d = 1'b0;
    case (state_q)
      S_TEST: begin
        // Code changes are ignored here; RUN picks up any difference later.
        if (blink_evt) begin
          if (test_q == TEST_LAST) begin
            state_d = S_RUN;
            test_d  = 8'd0;
          end else begin
            test_d = test_q + 8'd1;
          end
        end
      end
      S_RUN, S_BLANK: begin
        if (code_q != active_q) begin
          // A load also reinitialises the walk sequencer, so a coincident
          // blink event is deliberately dropped.
          state_d      = S_BLANK;
          active_d     = code_q;
          blank_d      = 16'd0;
          walk_cnt_d   = 8'd0;
          flash_d      = 1'b1;
          out_change_d = 1'b1;
        end else if (state_q == S_BLANK) begin
          if (blank_q == BLANK_LAST) state_d = S_RUN;
          else                       blank_d = blank_q + 16'd1;
        end else if (blink_evt && active_q == CODE_WALK) begin
          if (walk_cnt_q < WALK_STEADY) walk_cnt_d = walk_cnt_q + 8'd1;
          else                          flash_d    = ~flash_q;
        end
      end
      default: state_d = S_TEST;
    endcase
  end

  // Lamp decode from the upcoming state so lamps line up with state changes
  always_comb begin
    out_red_d    = 1'b0;
    out_yellow_d = 1'b0;
    out_green_d  = 1'b0;
    out_walk_d   = 1'b0;
    out_dwalk_d  = 1'b0;
    case (state_d)
      S_TEST: begin
        out_red_d    = 1'b1;
        out_yellow_d = 1'b1;
        out_green_d  = 1'b1;
        out_walk_d   = 1'b1;
        out_dwalk_d  = 1'b1;
      end
      S_RUN: begin
        case (active_d)
          CODE_RED: begin
            out_red_d   = en_red;
            out_dwalk_d = 1'b1;
          end
          CODE_GREEN: begin
            out_green_d = en_green;
            out_dwalk_d = 1'b1;
          end
          CODE_YELLOW: begin
            out_yellow_d = en_yellow;
            out_dwalk_d  = 1'b1;
          end
          default: begin
            out_red_d  = en_red;
            out_walk_d = (walk_cnt_d < WALK_STEADY) ? 1'b1 : flash_d;
          end
        endcase
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q      <= S_TEST;
      blink_s1_q   <= 1'b0;
      blink_s2_q   <= 1'b0;
      blink_s3_q   <= 1'b0;
      code_q       <= 2'b00;
      active_q     <= 2'b00;
      pwm_q        <= 8'd0;
      test_q       <= 8'd0;
      blank_q      <= 16'd0;
      walk_cnt_q   <= 8'd0;
      flash_q      <= 1'b1;
      out_red_q    <= 1'b0;
      out_yellow_q <= 1'b0;
      out_green_q  <= 1'b0;
      out_walk_q   <= 1'b0;
      out_dwalk_q  <= 1'b0;
      out_change_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blink_s1_q   <= blink_s1_d;
      blink_s2_q   <= blink_s2_d;
      blink_s3_q   <= blink_s3_d;
      code_q       <= code_d;
      active_q     <= active_d;
      pwm_q        <= pwm_d;
      test_q       <= test_d;
      blank_q      <= blank_d;
      walk_cnt_q   <= walk_cnt_d;
      flash_q      <= flash_d;
      out_red_q    <= out_red_d;
      out_yellow_q <= out_yellow_d;
      out_green_q  <= out_green_d;
      out_walk_q   <= out_walk_d;
      out_dwalk_q  <= out_dwalk_d;
      out_change_q <= out_change_d;
    end
  end

  assign outRed      = out_red_q;
  assign outYellow   = out_yellow_q;
  assign outGreen    = out_green_q;
  assign outWalk     = out_walk_q;
  assign outDontWalk = out_dwalk_q;
  assign outChange   = out_change_q;

endmodule

// File: tb/tb_light_driver.sv
// Directed bench for light_driver: lamp test, PWM duties, blanking gaps,
// walk sequencing and reset behaviour. A second instance has yellow duty 0.
module tb_light_driver;

  logic       clk;
  logic       rstb;
  logic       blink;
  logic [1:0] inLight;
  logic       o_red, o_yellow, o_green, o_walk, o_dwalk, o_change;
  logic       z_red, z_yellow, z_green, z_walk, z_dwalk, z_change;

  int total = 0;
  int bad   = 0;

  light_driver #(
    .C_DUTY_RED(255), .C_DUTY_GREEN(128), .C_DUTY_YELLOW(64),
    .C_TEST(4), .C_BLANK(10), .C_WALK_STEADY(3)
  ) dut (
    .clk(clk), .rstb(rstb), .blink(blink), .inLight(inLight),
    .outRed(o_red), .outYellow(o_yellow), .outGreen(o_green),
    .outWalk(o_walk), .outDontWalk(o_dwalk), .outChange(o_change)
  );

  light_driver #(
    .C_DUTY_RED(255), .C_DUTY_GREEN(128), .C_DUTY_YELLOW(0),
    .C_TEST(4), .C_BLANK(10), .C_WALK_STEADY(3)
  ) dut0 (
    .clk(clk), .rstb(rstb), .blink(blink), .inLight(inLight),
    .outRed(z_red), .outYellow(z_yellow), .outGreen(z_green),
    .outWalk(z_walk), .outDontWalk(z_dwalk), .outChange(z_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_blink();
    blink = 1'b1;
    repeat (4) tick();
    blink = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rstb = 1'b0; blink = 1'b0; inLight = 2'b00;
    repeat (3) tick();
    total++;
    if ({o_red, o_yellow, o_green, o_walk, o_dwalk, o_change} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=000000",
               {o_red, o_yellow, o_green, o_walk, o_dwalk, o_change});
    end
    total++;
    if ({z_red, z_yellow, z_green, z_walk, z_dwalk, z_change} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs_dut0 got=%b want=000000",
               {z_red, z_yellow, z_green, z_walk, z_dwalk, z_change});
    end
    rstb = 1'b1;
    tick();
    total++;
    if ({o_red, o_yellow, o_green, o_walk, o_dwalk, o_change} !== 6'b111110) begin
      bad++;
      $display("FAIL test_after_reset got=%b want=111110",
               {o_red, o_yellow, o_green, o_walk, o_dwalk, o_change});
    end
  endtask

  task automatic test_lamp_test();
    int reds;
    for (int e = 1; e <= 3; e++) begin
      pulse_blink();
      total++;
      if ({o_red, o_yellow, o_green, o_walk, o_dwalk} !== 5'b11111) begin
        bad++;
        $display("FAIL lamp_test_edge%0d got=%b want=11111", e,
                 {o_red, o_yellow, o_green, o_walk, o_dwalk});
      end
    end
    blink = 1'b1;
    tick();
    tick();
    total++;
    if ({o_red, o_yellow, o_green, o_walk, o_dwalk} !== 5'b11111) begin
      bad++;
      $display("FAIL lamp_test_hold got=%b want=11111",
               {o_red, o_yellow, o_green, o_walk, o_dwalk});
    end
    tick();
    total++;
    if ({o_yellow, o_green, o_walk, o_dwalk} !== 4'b0001) begin
      bad++;
      $display("FAIL run_entry ygwd got=%b want=0001",
               {o_yellow, o_green, o_walk, o_dwalk});
    end
    blink = 1'b0;
    repeat (4) tick();
    reds = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (o_red) reds++;
    end
    total++;
    if (reds !== 255) begin
      bad++;
      $display("FAIL red_duty got=%0d want=255", reds);
    end
  endtask

  task automatic test_change();
    int ch, zr, gr, other, dw;
    ch = 0; zr = 0;
    inLight = 2'b01;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_change) ch++;
      if ({o_red, o_yellow, o_green, o_walk, o_dwalk} === 5'b0) zr++;
    end
    total++;
    if (ch !== 1) begin
      bad++;
      $display("FAIL change_pulses got=%0d want=1", ch);
    end
    total++;
    if (zr !== 10) begin
      bad++;
      $display("FAIL blank_gap got=%0d want=10", zr);
    end
    gr = 0; other = 0; dw = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (o_green) gr++;
      if (o_red || o_yellow || o_walk) other++;
      if (o_dwalk) dw++;
    end
    total++;
    if (gr !== 128) begin
      bad++;
      $display("FAIL green_duty got=%0d want=128", gr);
    end
    total++;
    if (other !== 0 || dw !== 256) begin
      bad++;
      $display("FAIL green_others got=%0d/%0d want=0/256", other, dw);
    end
  endtask

  task automatic test_change_in_blank();
    int ch, zr;
    bit seen;
    ch = 0; zr = 0; seen = 1'b0;
    inLight = 2'b00;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (o_change) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL blank_restart_first got=no_change want=change");
    end
    ch = 1;
    if ({o_red, o_yellow, o_green, o_walk, o_dwalk} === 5'b0) zr++;
    for (int i = 1; i < 40; i++) begin
      if (i == 4) inLight = 2'b01;
      tick();
      if (o_change) ch++;
      if ({o_red, o_yellow, o_green, o_walk, o_dwalk} === 5'b0) zr++;
    end
    total++;
    if (ch !== 2) begin
      bad++;
      $display("FAIL blank_restart_pulses got=%0d want=2", ch);
    end
    total++;
    if (zr !== 15) begin
      bad++;
      $display("FAIL blank_restart_gap got=%0d want=15", zr);
    end
    total++;
    if ({o_red, o_yellow, o_walk, o_dwalk} !== 4'b0001) begin
      bad++;
      $display("FAIL blank_restart_final rywd got=%b want=0001",
               {o_red, o_yellow, o_walk, o_dwalk});
    end
  endtask

  task automatic test_walk();
    bit exp_w [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bit seen;
    seen = 1'b0;
    inLight = 2'b11;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (o_change) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL walk_change got=no_change want=change");
    end
    repeat (10) tick();
    total++;
    if ({o_yellow, o_green, o_walk, o_dwalk} !== 4'b0010) begin
      bad++;
      $display("FAIL walk_start ygwd got=%b want=0010",
               {o_yellow, o_green, o_walk, o_dwalk});
    end
    for (int e = 0; e < 7; e++) begin
      pulse_blink();
      total++;
      if (o_walk !== exp_w[e]) begin
        bad++;
        $display("FAIL walk_edge%0d got=%b want=%b", e + 1, o_walk, exp_w[e]);
      end
      total++;
      if ({o_dwalk, o_green, o_yellow} !== 3'b000) begin
        bad++;
        $display("FAIL walk_excl_edge%0d dgy got=%b want=000", e + 1,
                 {o_dwalk, o_green, o_yellow});
      end
    end
  endtask

  task automatic test_reset_mid_walk();
    rstb = 1'b0;
    tick();
    total++;
    if ({o_red, o_yellow, o_green, o_walk, o_dwalk, o_change} !== 6'b0) begin
      bad++;
      $display("FAIL midwalk_reset got=%b want=000000",
               {o_red, o_yellow, o_green, o_walk, o_dwalk, o_change});
    end
    rstb = 1'b1;
    tick();
    total++;
    if ({o_red, o_yellow, o_green, o_walk, o_dwalk, o_change} !== 6'b111110) begin
      bad++;
      $display("FAIL midwalk_restart got=%b want=111110",
               {o_red, o_yellow, o_green, o_walk, o_dwalk, o_change});
    end
  endtask

  task automatic test_change_in_test();
    int ch, zch, notlit, yl, zyl, zdw, rg;
    ch = 0; zch = 0; notlit = 0;
    for (int i = 0; i < 20; i++) begin
      inLight = 2'(i);
      tick();
      if (o_change) ch++;
      if (z_change) zch++;
      if ({o_red, o_yellow, o_green, o_walk, o_dwalk} !== 5'b11111) notlit++;
    end
    total++;
    if (ch !== 0 || zch !== 0) begin
      bad++;
      $display("FAIL test_ignores_change got=%0d/%0d want=0/0", ch, zch);
    end
    total++;
    if (notlit !== 0) begin
      bad++;
      $display("FAIL test_all_lit got=%0d unlit cycles want=0", notlit);
    end
    inLight = 2'b10;
    for (int e = 0; e < 4; e++) begin
      blink = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (o_change) ch++;
        if (z_change) zch++;
      end
      blink = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        if (o_change) ch++;
        if (z_change) zch++;
      end
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_change) ch++;
      if (z_change) zch++;
    end
    total++;
    if (ch !== 1 || zch !== 1) begin
      bad++;
      $display("FAIL run_picks_up_change got=%0d/%0d want=1/1", ch, zch);
    end
    yl = 0; zyl = 0; zdw = 0; rg = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (o_yellow) yl++;
      if (z_yellow) zyl++;
      if (z_dwalk) zdw++;
      if (o_red || o_green || o_walk) rg++;
    end
    total++;
    if (yl !== 64) begin
      bad++;
      $display("FAIL yellow_duty got=%0d want=64", yl);
    end
    total++;
    if (zyl !== 0) begin
      bad++;
      $display("FAIL yellow_duty0 got=%0d want=0", zyl);
    end
    total++;
    if (zdw !== 256 || rg !== 0) begin
      bad++;
      $display("FAIL yellow_others got=%0d/%0d want=256/0", zdw, rg);
    end
  endtask

  initial begin
    test_reset();
    test_lamp_test();
    test_change();
    test_change_in_blank();
    test_walk();
    test_reset_mid_walk();
    test_change_in_test();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/light_driver.md
LIGHT_DRIVER -- requirements
Module: light_driver

Interface
REQ-001 The module SHALL have parameter C_DUTY_RED, default 255, red lamp PWM duty (0..255, on-slots out of 256).
REQ-002 The module SHALL have parameter C_DUTY_GREEN, default 255, green lamp PWM duty (0..255).
REQ-003 The module SHALL have parameter C_DUTY_YELLOW, default 255, yellow lamp PWM duty (0..255).
REQ-004 The module SHALL have parameter C_TEST, default 4, lamp-test length in blink rising edges (1..255).
REQ-005 The module SHALL have parameter C_BLANK, default 1000, all-off gap between light codes in clk cycles (1..65535).
REQ-006 The module SHALL have parameter C_WALK_STEADY, default 50, steady walk period in blink rising edges before flashing starts (0..255).
REQ-007 The module SHALL have port clk, input, 1 bit: master clock.
REQ-008 The module SHALL have port rstb, input, 1 bit: reset, synchronous, active-low, sampled on posedge clk.
REQ-009 The module SHALL have port blink, input, 1 bit: asynchronous timebase square wave.
REQ-010 The module SHALL have port inLight, input, 2 bits: light code, 00 red, 01 green, 10 yellow, 11 walk.
REQ-011 The module SHALL have ports outRed, outYellow, outGreen, outWalk and outDontWalk, each an output of 1 bit: lamp drive, 1 = lit.
REQ-012 The module SHALL have port outChange, output, 1 bit: one-clk pulse on every accepted code change.

Function
REQ-013 All outputs SHALL be registered on posedge clk.
REQ-014 blink SHALL pass through a 2-FF synchronizer; the blink event SHALL be a one-clk pulse on a synchronized rising edge.
REQ-015 inLight SHALL be registered every clk into rCode.
REQ-016 An 8-bit free-running PWM counter SHALL increment every clk, wrap 255->0, and lamp X SHALL be PWM-enabled when counter < C_DUTY_X (duty 0 = never lit).
REQ-017 The FSM SHALL have states TEST, RUN and BLANK, hold an active code rActive, and leave reset in TEST.
REQ-018 In TEST, all five lamp outputs SHALL be 1 (no PWM); after C_TEST blink events the FSM SHALL go to RUN.
REQ-019 In RUN, when rCode != rActive the FSM SHALL go next cycle to BLANK, load rActive <= rCode and clear the blank counter, with outChange = 1 for exactly that cycle.
REQ-020 In BLANK, all lamp outputs SHALL be 0 and the counter SHALL increment each clk; when it reaches C_BLANK-1 with no change pending, the FSM SHALL go to RUN, so the gap is C_BLANK cycles.
REQ-021 A code change during BLANK SHALL reload rActive, restart the counter at 0 and pulse outChange again.
REQ-022 Code changes during TEST SHALL be ignored until RUN, and RUN SHALL then compare against rActive.
REQ-023 In RUN with rActive 00, 01 or 10, outRed, outGreen or outYellow respectively SHALL follow its PWM enable, with outDontWalk = 1 and outWalk = 0.
REQ-024 In RUN with rActive 11, outRed SHALL follow its PWM enable, outDontWalk SHALL be 0, and outWalk SHALL follow the walk sequencer.
REQ-025 The walk sequencer SHALL use an 8-bit count and a flash bit, and SHALL set count 0 and flash 1 on reset and on every rActive load.
REQ-026 On each blink event in RUN with rActive 11, the sequencer SHALL increment count if count < C_WALK_STEADY, else toggle flash.
REQ-027 outWalk SHALL be 1 while count < C_WALK_STEADY, else equal to flash; C_WALK_STEADY = 0 SHALL flash from the first event.
REQ-028 Walk and don't-walk lamps SHALL never both be 1 outside TEST, and no two of red/yellow/green SHALL be 1 outside TEST.
REQ-029 A blink event coincident with a code change SHALL be discarded by the sequencer, which is reinitialised by the load.

Reset
REQ-030 While rstb = 0 at posedge clk, all outputs SHALL be 0, state TEST, rActive = 00, rCode = 00, and all counters, synchronizer FFs and the PWM counter SHALL be 0, with flash = 1.
REQ-031 Reset asserted mid-BLANK or mid-walk SHALL abort immediately and the next non-reset cycle SHALL start TEST.

Verification (C_TEST=4, C_BLANK=10, C_WALK_STEADY=3, duties R/G/Y = 255/128/64)
REQ-032 Release reset and give 4 blink edges -> all lamps 1 until about 3 clk after the 4th edge, then outRed at 255/256 duty and outDontWalk = 1.
REQ-033 In RUN, switch inLight 00->01 -> outChange pulses once, lamps stay 0 for exactly 10 cycles, then outGreen is high for 128 of every 256 cycles.
REQ-034 Switch inLight to 01 at BLANK cycle 5 -> outChange pulses again and the gap extends to 5+10 cycles total from the first change.
REQ-035 Set inLight = 11 and apply 7 blink edges -> outWalk is 1 for edges 1-3, then after edges 4..7 toggles 0,1,0,1, with outDontWalk = 0.
REQ-036 Apply inLight changes during TEST and duty 0 on yellow -> no outChange during TEST, and outYellow is never 1 in RUN with code 10.
REQ-037 Assert rstb = 0 mid-walk flash -> all outputs 0 on the next clk, then TEST restarts.
